// File: rtl/scs8hd_bist_pkg.sv
// Shared types and constants for the 2-input cell BIST driver.
// Holds the FSM state encoding, the Gray vector order, reference truth tables and the saturating counter helper.
package scs8hd_bist_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        FINISH = 2'd3
    } bist_state_e;

    // {B,A} per step; only one input changes between neighbours
    localparam logic [1:0] VEC_ORDER [0:3] = '{2'b00, 2'b01, 2'b11, 2'b10};

    localparam logic [3:0] NAND2_TT = 4'b0111;
    localparam logic [3:0] NOR2_TT  = 4'b0001;
    localparam logic [7:0] ERR_MAX  = 8'hFF;

    function automatic logic [7:0] sat_inc(input logic [7:0] value);
        logic [7:0] result;
        if (value == ERR_MAX) begin
            result = value;
        end else begin
            result = value + 8'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/scs8hd_bist_sync2.sv
// Two-flop synchronizer for the observed cell output.
// Both stages clear to 0 on the asynchronous active-high reset.
module scs8hd_bist_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Two back-to-back capture stages
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/scs8hd_cell2_bist.sv
// BIST driver for a 2-input combinational cell: walks the four {B,A} vectors in Gray order and compares Y to EXP_TT.
// Define SCS8HD_BIST_SYNC_EN to synchronize obs_Y through two flops and lengthen each drive hold by two cycles.
module scs8hd_cell2_bist
    import scs8hd_bist_pkg::*;
#(
    parameter int         SETTLE_CYCLES = 2,
    parameter logic [3:0] EXP_TT        = NAND2_TT,
    parameter int         LOOPS         = 1
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       start,
    input  logic       abort,
    output logic       drv_A,
    output logic       drv_B,
    input  logic       obs_Y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_vec,
    output logic [7:0] err_cnt
);

    localparam int SETTLE_EFF = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
`ifdef SCS8HD_BIST_SYNC_EN
    localparam int HOLD = SETTLE_EFF + 2;
`else
    localparam int HOLD = SETTLE_EFF;
`endif
    localparam logic [15:0] HOLD_LD = 16'(HOLD - 1);
    localparam logic [15:0] LOOPS_W = 16'(LOOPS);

    logic obs_cmp;

`ifdef SCS8HD_BIST_SYNC_EN
    scs8hd_bist_sync2 u_sync (
        .clk (CLK),
        .rst (RESET),
        .d   (obs_Y),
        .q   (obs_cmp)
    );
`else
    assign obs_cmp = obs_Y;
`endif

    bist_state_e state, state_nx;
    logic [1:0]  idx, idx_nx;
    logic [15:0] loop_cnt, loop_nx;
    logic [15:0] hold_cnt, hold_nx;
    logic [1:0]  vec;
    logic        drv_a_nx, drv_b_nx, busy_nx, done_nx, pass_nx;
    logic [3:0]  fail_nx;
    logic [7:0]  err_nx;

    assign vec = VEC_ORDER[idx];

    // Next-state, counter and output-register values
    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        loop_nx  = loop_cnt;
        hold_nx  = hold_cnt;
        fail_nx  = fail_vec;
        err_nx   = err_cnt;
        pass_nx  = pass;
        drv_a_nx = 1'b0;
        drv_b_nx = 1'b0;
        busy_nx  = 1'b0;
        done_nx  = 1'b0;

        if (abort && (state != IDLE)) begin
            state_nx = IDLE;
            pass_nx  = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        state_nx = DRIVE;
                        idx_nx   = 2'd0;
                        loop_nx  = 16'd0;
                        hold_nx  = HOLD_LD;
                        fail_nx  = 4'b0000;
                        err_nx   = 8'd0;
                        pass_nx  = 1'b0;
                    end else begin
                        state_nx = IDLE;
                    end
                end
                DRIVE: begin
                    if (hold_cnt == 16'd0) begin
                        state_nx = SAMPLE;
                    end else begin
                        hold_nx = hold_cnt - 16'd1;
                    end
                end
                SAMPLE: begin
                    if (obs_cmp != EXP_TT[vec]) begin
                        fail_nx[vec] = 1'b1;
                        err_nx       = sat_inc(err_cnt);
                    end else begin
                        err_nx = err_cnt;
                    end
                    idx_nx  = idx + 2'd1;
                    hold_nx = HOLD_LD;
                    if ((idx == 2'd3) && ((loop_cnt + 16'd1) == LOOPS_W)) begin
                        loop_nx  = loop_cnt + 16'd1;
                        state_nx = FINISH;
                    end else if (idx == 2'd3) begin
                        loop_nx  = loop_cnt + 16'd1;
                        state_nx = DRIVE;
                    end else begin
                        state_nx = DRIVE;
                    end
                end
                FINISH: begin
                    state_nx = IDLE;
                end
                default: begin
                    state_nx = IDLE;
                end
            endcase
        end

        // Outputs are registered from the upcoming state so they line up with it
        if ((state_nx == DRIVE) || (state_nx == SAMPLE)) begin
            {drv_b_nx, drv_a_nx} = VEC_ORDER[idx_nx];
        end else begin
            {drv_b_nx, drv_a_nx} = 2'b00;
        end
        busy_nx = (state_nx != IDLE);
        if (state_nx == FINISH) begin
            done_nx = 1'b1;
            pass_nx = (err_nx == 8'd0);
        end else begin
            done_nx = 1'b0;
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state    <= IDLE;
            idx      <= 2'd0;
            loop_cnt <= 16'd0;
            hold_cnt <= 16'd0;
            drv_A    <= 1'b0;
            drv_B    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            fail_vec <= 4'b0000;
            err_cnt  <= 8'd0;
        end else begin
            state    <= state_nx;
            idx      <= idx_nx;
            loop_cnt <= loop_nx;
            hold_cnt <= hold_nx;
            drv_A    <= drv_a_nx;
            drv_B    <= drv_b_nx;
            busy     <= busy_nx;
            done     <= done_nx;
            pass     <= pass_nx;
            fail_vec <= fail_nx;
            err_cnt  <= err_nx;
        end
    end

endmodule

// File: tb/tb_scs8hd_cell2_bist.sv
// Randomized self-checking bench: three BIST instances (LOOPS 1, 3, 100) each drive a nand2 model with an injectable fault mask.
module tb_scs8hd_cell2_bist;

`ifdef SCS8HD_BIST_SYNC_EN
    localparam int P = 2 + 3;
`else
    localparam int P = 2 + 1;
`endif

    logic       clk;
    logic       rst;
    logic [2:0] start_v, abort_v, drv_a, drv_b, obs, busy, done, pass;
    logic [3:0] fv [3];
    logic [7:0] ec [3];
    logic [3:0] mask [3];
    int checks, errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cell model: nand2 with Y inverted on every {B,A} selected by the fault mask
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            obs[i] = ~(drv_a[i] & drv_b[i]) ^ mask[i][{drv_b[i], drv_a[i]}];
        end
    end

    scs8hd_cell2_bist #(.LOOPS(1)) u0 (
        .CLK(clk), .RESET(rst), .start(start_v[0]), .abort(abort_v[0]),
        .drv_A(drv_a[0]), .drv_B(drv_b[0]), .obs_Y(obs[0]), .busy(busy[0]),
        .done(done[0]), .pass(pass[0]), .fail_vec(fv[0]), .err_cnt(ec[0]));
    scs8hd_cell2_bist #(.LOOPS(3)) u1 (
        .CLK(clk), .RESET(rst), .start(start_v[1]), .abort(abort_v[1]),
        .drv_A(drv_a[1]), .drv_B(drv_b[1]), .obs_Y(obs[1]), .busy(busy[1]),
        .done(done[1]), .pass(pass[1]), .fail_vec(fv[1]), .err_cnt(ec[1]));
    scs8hd_cell2_bist #(.LOOPS(100)) u2 (
        .CLK(clk), .RESET(rst), .start(start_v[2]), .abort(abort_v[2]),
        .drv_A(drv_a[2]), .drv_B(drv_b[2]), .obs_Y(obs[2]), .busy(busy[2]),
        .done(done[2]), .pass(pass[2]), .fail_vec(fv[2]), .err_cnt(ec[2]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start a test at cycle 0 on instance i and check drive order, done timing and final results
    task automatic run(input int i, input int loops, input logic [3:0] m, input int restart_at);
        int c, done_at, exp_err, k, g;
        mask[i] = m;
        start_v[i] = 1'b1;
        tick();
        start_v[i] = 1'b0;
        c = 1;
        done_at = -1;
        check("busy_after_start", 32'(busy[i]), 32'd1);
        while (done_at < 0 && c <= 4 * loops * P + 10) begin
            if (done[i]) begin
                done_at = c;
            end else begin
                if (c <= 4 * P && (c % P) == 0) begin
                    k = c / P - 1;
                    g = k ^ (k >> 1);
                    check("drive_gray", 32'({drv_b[i], drv_a[i]}), 32'(g));
                end
                if (c == restart_at) start_v[i] = 1'b1;
                tick();
                start_v[i] = 1'b0;
                c++;
            end
        end
        exp_err = $countones(m) * loops;
        if (exp_err > 255) exp_err = 255;
        check("done_cycle", 32'(done_at), 32'(1 + 4 * loops * P));
        check("pass", 32'(pass[i]), 32'(m == 4'b0000));
        check("fail_vec", 32'(fv[i]), 32'(m));
        check("err_cnt", 32'(ec[i]), 32'(exp_err));
        tick();
        check("done_one_cycle", 32'(done[i]), 32'd0);
        check("busy_end", 32'(busy[i]), 32'd0);
        check("drive_end", 32'({drv_b[i], drv_a[i]}), 32'd0);
        check("pass_held", 32'(pass[i]), 32'(m == 4'b0000));
    endtask

    initial begin
        logic [3:0] m;
        int sel;
        checks = 0;
        errors = 0;
        start_v = 3'b000;
        abort_v = 3'b000;
        for (int i = 0; i < 3; i++) mask[i] = 4'b0000;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("rst_busy", 32'(busy[i]), 32'd0);
            check("rst_done", 32'(done[i]), 32'd0);
            check("rst_pass", 32'(pass[i]), 32'd0);
            check("rst_drive", 32'({drv_b[i], drv_a[i]}), 32'd0);
            check("rst_fail_vec", 32'(fv[i]), 32'd0);
            check("rst_err_cnt", 32'(ec[i]), 32'd0);
        end

        run(0, 1, 4'b0000, -1);
        run(0, 1, 4'b1000, -1);
        run(1, 3, 4'b1000, -1);
        run(2, 100, 4'b0111, -1);
        for (int r = 0; r < 8; r++) begin
            sel = $urandom_range(0, 1);
            m = 4'($urandom_range(0, 15));
            run(sel, (sel == 0) ? 1 : 3, m, -1);
        end
        // second start at cycle 4 must be ignored
        run(0, 1, 4'b0110, 4);

        // abort at cycle 5 keeps partial results, then restart at cycle 7
        mask[0] = 4'b0011;
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        for (int c = 1; c < 5; c++) tick();
        abort_v[0] = 1'b1;
        tick();
        abort_v[0] = 1'b0;
        check("abort_busy", 32'(busy[0]), 32'd0);
        check("abort_done", 32'(done[0]), 32'd0);
        check("abort_drive", 32'({drv_b[0], drv_a[0]}), 32'd0);
        check("abort_pass", 32'(pass[0]), 32'd0);
        check("abort_err_cnt", 32'(ec[0]), 32'd1);
        check("abort_fail_vec", 32'(fv[0]), 32'd1);
        tick();
        check("abort_no_done", 32'(done[0]), 32'd0);
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        check("restart_busy", 32'(busy[0]), 32'd1);
        check("restart_err_cnt", 32'(ec[0]), 32'd0);
        check("restart_fail_vec", 32'(fv[0]), 32'd0);
        abort_v[0] = 1'b1;
        tick();
        abort_v[0] = 1'b0;
        check("abort2_busy", 32'(busy[0]), 32'd0);

        // start together with abort in IDLE is not accepted
        run(0, 1, 4'b1000, -1);
        start_v[0] = 1'b1;
        abort_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        abort_v[0] = 1'b0;
        check("start_abort_busy", 32'(busy[0]), 32'd0);
        check("start_abort_err_cnt", 32'(ec[0]), 32'd1);
        tick();
        check("start_abort_busy2", 32'(busy[0]), 32'd0);

        // reset at cycle 8 of a test
        mask[0] = 4'b0001;
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        for (int c = 1; c < 8; c++) tick();
        check("pre_reset_err_cnt", 32'(ec[0]), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_busy", 32'(busy[0]), 32'd0);
        check("mid_rst_drive", 32'({drv_b[0], drv_a[0]}), 32'd0);
        check("mid_rst_err_cnt", 32'(ec[0]), 32'd0);
        check("mid_rst_fail_vec", 32'(fv[0]), 32'd0);
        check("mid_rst_pass", 32'(pass[0]), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            check("post_rst_no_done", 32'(done[0]), 32'd0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
